ex_mem_mdu: RTL and testbench

- Execute stage plus EX/MEM pipeline latch for the MIPS core, parametrised in data width.
- Adds an iterative multiply/divide unit (MDU) with HI/LO registers, MFHI/MFLO readout and a stall handshake toward the hazard unit.
- Sits between ID_EX and MEM, with the same forwarding role as the current EX/MEM latch.
- Plain ALU instructions keep single-cycle flow.

---
 rtl/ex_mem_mdu.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_ex_mem_mdu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_mdu.sv
// Execute stage and EX/MEM latch with an iterative multiply/divide unit.
// HI/LO are readable with MFHI/MFLO; stall_ex holds upstream stages while MDU instructions wait for a busy unit.
module ex_mem_mdu #(
    parameter int LEN_DATA    = 32,
    parameter int NUM_BITS    = 5,
    parameter int LEN_MEM_BUS = 9,
    parameter int LEN_WB_BUS  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LEN_DATA-1:0]    in_pc,
    input  logic [LEN_DATA-1:0]    in_reg1,
    input  logic [LEN_DATA-1:0]    in_reg2,
    input  logic [LEN_DATA-1:0]    in_sign_extend,
    input  logic [NUM_BITS-1:0]    in_rs,
    input  logic [NUM_BITS-1:0]    in_rt,
    input  logic [NUM_BITS-1:0]    in_rd,
    input  logic [NUM_BITS-1:0]    in_shamt,
    input  logic [3:0]             alu_op,
    input  logic                   alu_src_imm,
    input  logic                   alu_src_shamt,
    input  logic                   link,
    input  logic                   reg_dst,
    input  logic [2:0]             mdu_op,
    input  logic [LEN_MEM_BUS-1:0] memory_bus,
    input  logic [LEN_WB_BUS-1:0]  writeBack_bus,
    input  logic                   ex_mem_reg_write,
    input  logic                   mem_wb_reg_write,
    input  logic [NUM_BITS-1:0]    ex_mem_rd,
    input  logic [NUM_BITS-1:0]    mem_wb_rd,
    input  logic [LEN_DATA-1:0]    in_mem_forw,
    input  logic [LEN_DATA-1:0]    in_wb_forw,
    input  logic                   flush,
    input  logic                   halt_flag_e,
    output logic                   stall_ex,
    output logic                   mdu_busy,
    output logic [LEN_DATA-1:0]    out_pc_branch,
    output logic [LEN_DATA-1:0]    out_alu,
    output logic [LEN_DATA-1:0]    out_reg2,
    output logic                   zero_flag,
    output logic [NUM_BITS-1:0]    out_write_reg,
    output logic                   out_halt_flag_e,
    output logic [LEN_MEM_BUS-1:0] memory_bus_out,
    output logic [LEN_WB_BUS-1:0]  writeBack_bus_out
);

    localparam int CNT_W = $clog2(LEN_DATA);
    localparam int SH_W  = $clog2(LEN_DATA);
    localparam logic [LEN_DATA-1:0]   ONE      = {{(LEN_DATA-1){1'b0}}, 1'b1};
    localparam logic [2*LEN_DATA-1:0] ONE2     = {{(2*LEN_DATA-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(LEN_DATA - 1);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [2:0] MDU_MULT  = 3'b001;
    localparam logic [2:0] MDU_MULTU = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;
    localparam logic [2:0] MDU_DIVU  = 3'b100;
    localparam logic [2:0] MDU_MFHI  = 3'b101;
    localparam logic [2:0] MDU_MFLO  = 3'b110;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    function automatic logic [LEN_DATA-1:0] f_neg(input logic [LEN_DATA-1:0] x);
        return ~x + ONE;
    endfunction

    function automatic logic [2*LEN_DATA-1:0] f_neg2(input logic [2*LEN_DATA-1:0] x);
        return ~x + ONE2;
    endfunction

    state_t                 r_state;
    state_t                 w_state_n;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_is_div;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic [LEN_DATA-1:0]    r_a;
    logic [LEN_DATA-1:0]    r_acc;
    logic [LEN_DATA-1:0]    r_q;
    logic [LEN_DATA-1:0]    r_hi;
    logic [LEN_DATA-1:0]    r_lo;

    logic [LEN_DATA-1:0]    w_fwd_a;
    logic [LEN_DATA-1:0]    w_fwd_b;
    logic [LEN_DATA-1:0]    w_alu_a;
    logic [LEN_DATA-1:0]    w_alu_b;
    logic [LEN_DATA-1:0]    w_alu_res;
    logic [LEN_DATA-1:0]    w_result;
    logic [NUM_BITS-1:0]    w_dst;
    logic                   w_is_arith;
    logic                   w_is_any;
    logic                   w_start;
    logic                   w_signed;
    logic                   w_op_div;
    logic                   w_sign_a;
    logic                   w_sign_b;
    logic [LEN_DATA-1:0]    w_mag_a;
    logic [LEN_DATA-1:0]    w_mag_b;
    logic [LEN_DATA:0]      w_msum;
    logic [LEN_DATA:0]      w_shift;
    logic                   w_ge;
    logic [LEN_DATA-1:0]    w_diff;
    logic [LEN_DATA-1:0]    w_acc_n;
    logic [LEN_DATA-1:0]    w_q_n;
    logic [2*LEN_DATA-1:0]  w_prod;
    logic [2*LEN_DATA-1:0]  w_prod_fix;
    logic [LEN_DATA-1:0]    w_hi_fin;
    logic [LEN_DATA-1:0]    w_lo_fin;

    // Operand forwarding: EX/MEM beats MEM/WB beats the register file
    always_comb begin
        w_fwd_a = in_reg1;
        w_fwd_b = in_reg2;
        if (ex_mem_reg_write && (ex_mem_rd != {NUM_BITS{1'b0}}) && (ex_mem_rd == in_rs)) begin
            w_fwd_a = in_mem_forw;
        end else if (mem_wb_reg_write && (mem_wb_rd != {NUM_BITS{1'b0}}) && (mem_wb_rd == in_rs)) begin
            w_fwd_a = in_wb_forw;
        end else begin
            w_fwd_a = in_reg1;
        end
        if (ex_mem_reg_write && (ex_mem_rd != {NUM_BITS{1'b0}}) && (ex_mem_rd == in_rt)) begin
            w_fwd_b = in_mem_forw;
        end else if (mem_wb_reg_write && (mem_wb_rd != {NUM_BITS{1'b0}}) && (mem_wb_rd == in_rt)) begin
            w_fwd_b = in_wb_forw;
        end else begin
            w_fwd_b = in_reg2;
        end
    end

    // ALU operand and destination selection
    always_comb begin
        w_alu_a = w_fwd_a;
        w_alu_b = w_fwd_b;
        w_dst   = in_rt;
        if (link) begin
            w_alu_a = in_pc;
            w_alu_b = ONE;
            w_dst   = {NUM_BITS{1'b1}};
        end else begin
            w_alu_a = alu_src_shamt ? {{(LEN_DATA-NUM_BITS){1'b0}}, in_shamt} : w_fwd_a;
            w_alu_b = alu_src_imm ? in_sign_extend : w_fwd_b;
            w_dst   = reg_dst ? in_rd : in_rt;
        end
    end

    // ALU; shift instructions shift B by the low bits of A
    always_comb begin
        w_alu_res = {LEN_DATA{1'b0}};
        case (alu_op)
            ALU_ADD:  w_alu_res = w_alu_a + w_alu_b;
            ALU_SUB:  w_alu_res = w_alu_a - w_alu_b;
            ALU_AND:  w_alu_res = w_alu_a & w_alu_b;
            ALU_OR:   w_alu_res = w_alu_a | w_alu_b;
            ALU_XOR:  w_alu_res = w_alu_a ^ w_alu_b;
            ALU_NOR:  w_alu_res = ~(w_alu_a | w_alu_b);
            ALU_SLT:  w_alu_res = {{(LEN_DATA-1){1'b0}}, ($signed(w_alu_a) < $signed(w_alu_b))};
            ALU_SLTU: w_alu_res = {{(LEN_DATA-1){1'b0}}, (w_alu_a < w_alu_b)};
            ALU_SLL:  w_alu_res = w_alu_b << w_alu_a[SH_W-1:0];
            ALU_SRL:  w_alu_res = w_alu_b >> w_alu_a[SH_W-1:0];
            ALU_SRA:  w_alu_res = $signed(w_alu_b) >>> w_alu_a[SH_W-1:0];
            ALU_LUI:  w_alu_res = w_alu_b << (LEN_DATA / 2);
            default:  w_alu_res = w_alu_a + w_alu_b;
        endcase
    end

    // MDU decode, start condition and operand magnitudes
    always_comb begin
        w_is_arith = (mdu_op >= MDU_MULT) && (mdu_op <= MDU_DIVU);
        w_is_any   = (mdu_op >= MDU_MULT) && (mdu_op <= MDU_MFLO);
        stall_ex   = (r_state == S_BUSY) && w_is_any;
        w_start    = (r_state == S_IDLE) && w_is_arith && !flush && !stall_ex;
        w_signed   = (mdu_op == MDU_MULT) || (mdu_op == MDU_DIV);
        w_op_div   = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
        w_sign_a   = w_signed && w_fwd_a[LEN_DATA-1];
        w_sign_b   = w_signed && w_fwd_b[LEN_DATA-1];
        w_mag_a    = w_sign_a ? f_neg(w_fwd_a) : w_fwd_a;
        w_mag_b    = w_sign_b ? f_neg(w_fwd_b) : w_fwd_b;
        w_result   = w_alu_res;
        case (mdu_op)
            MDU_MFHI: w_result = r_hi;
            MDU_MFLO: w_result = r_lo;
            default:  w_result = w_alu_res;
        endcase
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        w_msum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_a} : {(LEN_DATA+1){1'b0}});
        w_shift = {r_acc, r_q[LEN_DATA-1]};
        w_ge    = (w_shift >= {1'b0, r_a});
        w_diff  = w_shift[LEN_DATA-1:0] - r_a;
        if (r_is_div) begin
            w_acc_n = w_ge ? w_diff : w_shift[LEN_DATA-1:0];
            w_q_n   = {r_q[LEN_DATA-2:0], w_ge};
        end else begin
            w_acc_n = w_msum[LEN_DATA:1];
            w_q_n   = {w_msum[0], r_q[LEN_DATA-1:1]};
        end
        w_prod     = {w_acc_n, w_q_n};
        w_prod_fix = r_neg_q ? f_neg2(w_prod) : w_prod;
        if (r_is_div) begin
            w_hi_fin = r_neg_r ? f_neg(w_acc_n) : w_acc_n;
            w_lo_fin = r_neg_q ? f_neg(w_q_n) : w_q_n;
        end else begin
            w_hi_fin = w_prod_fix[2*LEN_DATA-1:LEN_DATA];
            w_lo_fin = w_prod_fix[LEN_DATA-1:0];
        end
    end

    // MDU next-state logic
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  w_state_n = w_start ? S_BUSY : S_IDLE;
            S_BUSY:  w_state_n = (r_cnt == {CNT_W{1'b0}}) ? S_IDLE : S_BUSY;
            default: w_state_n = S_IDLE;
        endcase
    end

    assign mdu_busy = (r_state == S_BUSY);

    // MDU state register
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // MDU datapath: operand capture, iteration and HI/LO write-back
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_a      <= {LEN_DATA{1'b0}};
            r_acc    <= {LEN_DATA{1'b0}};
            r_q      <= {LEN_DATA{1'b0}};
            r_hi     <= {LEN_DATA{1'b0}};
            r_lo     <= {LEN_DATA{1'b0}};
        end else if (w_start) begin
            r_cnt    <= CNT_LAST;
            r_is_div <= w_op_div;
            r_neg_q  <= w_sign_a ^ w_sign_b;
            r_neg_r  <= w_sign_a;
            r_acc    <= {LEN_DATA{1'b0}};
            r_a      <= w_op_div ? w_mag_b : w_mag_a;
            r_q      <= w_op_div ? w_mag_a : w_mag_b;
        end else if (r_state == S_BUSY) begin
            r_acc <= w_acc_n;
            r_q   <= w_q_n;
            if (r_cnt == {CNT_W{1'b0}}) begin
                r_hi <= w_hi_fin;
                r_lo <= w_lo_fin;
            end else begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    // EX/MEM latch: stall inserts a control bubble and holds data, flush clears
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            out_pc_branch     <= {LEN_DATA{1'b0}};
            out_alu           <= {LEN_DATA{1'b0}};
            out_reg2          <= {LEN_DATA{1'b0}};
            zero_flag         <= 1'b0;
            out_write_reg     <= {NUM_BITS{1'b0}};
            out_halt_flag_e   <= 1'b0;
            memory_bus_out    <= {LEN_MEM_BUS{1'b0}};
            writeBack_bus_out <= {LEN_WB_BUS{1'b0}};
        end else begin
            out_halt_flag_e <= halt_flag_e;
            if (stall_ex) begin
                memory_bus_out    <= {LEN_MEM_BUS{1'b0}};
                writeBack_bus_out <= {LEN_WB_BUS{1'b0}};
            end else if (flush) begin
                out_pc_branch     <= {LEN_DATA{1'b0}};
                out_alu           <= {LEN_DATA{1'b0}};
                out_reg2          <= {LEN_DATA{1'b0}};
                zero_flag         <= 1'b0;
                out_write_reg     <= {NUM_BITS{1'b0}};
                memory_bus_out    <= {LEN_MEM_BUS{1'b0}};
                writeBack_bus_out <= {LEN_WB_BUS{1'b0}};
            end else begin
                out_pc_branch     <= in_pc + in_sign_extend;
                out_alu           <= w_result;
                out_reg2          <= w_fwd_b;
                zero_flag         <= (w_alu_res == {LEN_DATA{1'b0}});
                out_write_reg     <= w_dst;
                memory_bus_out    <= memory_bus;
                writeBack_bus_out <= writeBack_bus;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_mdu.sv
// Directed bench for ex_mem_mdu: forwarding, ALU paths, MDU results/latency, flush and reset.
module tb_ex_mem_mdu;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLL = 4'd8;
    localparam logic [2:0] OP_MULT = 3'b001, OP_MULTU = 3'b010, OP_DIV = 3'b011,
                           OP_DIVU = 3'b100, OP_MFHI = 3'b101, OP_MFLO = 3'b110;

    logic        clk, reset;
    logic [31:0] in_pc, in_reg1, in_reg2, in_sign_extend;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [3:0]  alu_op;
    logic        alu_src_imm, alu_src_shamt, link, reg_dst;
    logic [2:0]  mdu_op;
    logic [8:0]  memory_bus;
    logic [1:0]  writeBack_bus;
    logic        ex_mem_reg_write, mem_wb_reg_write;
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic [31:0] in_mem_forw, in_wb_forw;
    logic        flush, halt_flag_e;
    logic        stall_ex, mdu_busy;
    logic [31:0] out_pc_branch, out_alu, out_reg2;
    logic        zero_flag;
    logic [4:0]  out_write_reg;
    logic        out_halt_flag_e;
    logic [8:0]  memory_bus_out;
    logic [1:0]  writeBack_bus_out;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] m_hi, m_lo;

    ex_mem_mdu dut (
        .clk(clk), .reset(reset), .in_pc(in_pc), .in_reg1(in_reg1), .in_reg2(in_reg2),
        .in_sign_extend(in_sign_extend), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .alu_src_shamt(alu_src_shamt), .link(link), .reg_dst(reg_dst), .mdu_op(mdu_op),
        .memory_bus(memory_bus), .writeBack_bus(writeBack_bus),
        .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_reg_write(mem_wb_reg_write),
        .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd), .in_mem_forw(in_mem_forw),
        .in_wb_forw(in_wb_forw), .flush(flush), .halt_flag_e(halt_flag_e),
        .stall_ex(stall_ex), .mdu_busy(mdu_busy), .out_pc_branch(out_pc_branch),
        .out_alu(out_alu), .out_reg2(out_reg2), .zero_flag(zero_flag),
        .out_write_reg(out_write_reg), .out_halt_flag_e(out_halt_flag_e),
        .memory_bus_out(memory_bus_out), .writeBack_bus_out(writeBack_bus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_check();
        string t;
        logic [31:0] v;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL sb_empty: observed %0h expected none", out_alu);
        end else begin
            t = tag_q.pop_front();
            v = exp_q.pop_front();
            chk(t, {32'd0, out_alu}, {32'd0, v});
        end
    endtask

    task automatic clr_in();
        in_pc = 32'd0; in_reg1 = 32'd0; in_reg2 = 32'd0; in_sign_extend = 32'd0;
        in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0;
        alu_op = ALU_ADD; alu_src_imm = 1'b0; alu_src_shamt = 1'b0; link = 1'b0; reg_dst = 1'b0;
        mdu_op = 3'b000; memory_bus = 9'd0; writeBack_bus = 2'd0;
        ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0; ex_mem_rd = 5'd0; mem_wb_rd = 5'd0;
        in_mem_forw = 32'd0; in_wb_forw = 32'd0; flush = 1'b0; halt_flag_e = 1'b0;
    endtask

    // Reference model for HI/LO (non-zero divisors only)
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        p  = 64'd0;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            OP_MULT:  begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; hi = p[63:32]; lo = p[31:0]; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            OP_DIV:   begin lo = sa / sb; hi = sa % sb; end
            OP_DIVU:  begin lo = a / b; hi = a % b; end
            default:  begin hi = 32'd0; lo = 32'd0; end
        endcase
    endtask

    task automatic run_mdu(input string nm, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                           input bit overlap);
        int cnt;
        clr_in();
        in_reg1 = a; in_reg2 = b; in_rs = 5'd1; in_rt = 5'd2; mdu_op = op; writeBack_bus = 2'b01;
        tick();
        chk({nm, "_busy"}, {63'd0, mdu_busy}, 64'd1);
        cnt = 0;
        if (overlap) begin
            clr_in();
            in_reg1 = 32'd10; in_reg2 = 32'd20; alu_op = ALU_ADD; writeBack_bus = 2'b01;
            #1;
            chk("add_nostall", {63'd0, stall_ex}, 64'd0);
            sb_push("add_overlap", 32'd30);
            tick();
            sb_check();
            chk("busy_overlap", {63'd0, mdu_busy}, 64'd1);
            cnt = 1;
        end
        clr_in();
        mdu_op = OP_MFLO; writeBack_bus = 2'b11;
        #1;
        while (stall_ex === 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        chk({nm, "_stall_len"}, cnt, 64'd32);
        chk({nm, "_bubble"}, {62'd0, writeBack_bus_out}, 64'd0);
        if (overlap) chk("hold_alu", {32'd0, out_alu}, 64'd30);
        sb_push({nm, "_lo"}, elo);
        tick();
        sb_check();
        chk({nm, "_wb"}, {62'd0, writeBack_bus_out}, 64'd3);
        clr_in();
        mdu_op = OP_MFHI;
        sb_push({nm, "_hi"}, ehi);
        tick();
        sb_check();
    endtask

    initial begin
        clr_in();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_alu", {32'd0, out_alu}, 64'd0);
        chk("rst_busy", {63'd0, mdu_busy}, 64'd0);
        chk("rst_mem", {55'd0, memory_bus_out}, 64'd0);
        tick();
        reset = 1'b1;

        // forwarding priority: EX/MEM over MEM/WB
        clr_in();
        in_reg1 = 32'd300; in_reg2 = 32'd7; in_mem_forw = 32'd100; in_wb_forw = 32'd200;
        in_rs = 5'd5; in_rt = 5'd6; ex_mem_rd = 5'd5; mem_wb_rd = 5'd5;
        ex_mem_reg_write = 1'b1; mem_wb_reg_write = 1'b1;
        reg_dst = 1'b1; in_rd = 5'd9; in_pc = 32'd16; in_sign_extend = 32'd4;
        memory_bus = 9'h0A5; writeBack_bus = 2'b10;
        sb_push("fwd_exmem", 32'd107);
        tick();
        sb_check();
        chk("reg2", {32'd0, out_reg2}, 64'd7);
        chk("wr_reg", {59'd0, out_write_reg}, 64'd9);
        chk("pc_branch", {32'd0, out_pc_branch}, 64'd20);
        chk("mem_bus", {55'd0, memory_bus_out}, 64'h0A5);
        chk("wb_bus", {62'd0, writeBack_bus_out}, 64'd2);

        ex_mem_rd = 5'd3;
        sb_push("fwd_memwb", 32'd207);
        tick();
        sb_check();

        ex_mem_rd = 5'd0; mem_wb_rd = 5'd0; in_rs = 5'd0;
        sb_push("fwd_rd0", 32'd307);
        tick();
        sb_check();

        in_rt = 5'd5; ex_mem_rd = 5'd5; in_rs = 5'd0;
        sb_push("fwd_rt", 32'd400);
        tick();
        sb_check();
        chk("fwd_reg2", {32'd0, out_reg2}, 64'd100);

        // link, immediate subtract to zero, shamt shift
        clr_in();
        link = 1'b1; in_pc = 32'd40; in_reg1 = 32'd77;
        sb_push("link", 32'd41);
        tick();
        sb_check();
        chk("link_reg", {59'd0, out_write_reg}, 64'd31);

        clr_in();
        alu_op = ALU_SUB; in_reg1 = 32'd25; alu_src_imm = 1'b1; in_sign_extend = 32'd25;
        sb_push("sub_zero", 32'd0);
        tick();
        sb_check();
        chk("zero_flag", {63'd0, zero_flag}, 64'd1);

        clr_in();
        alu_op = ALU_SLL; alu_src_shamt = 1'b1; in_shamt = 5'd4; in_reg2 = 32'd3;
        sb_push("sll", 32'd48);
        tick();
        sb_check();

        // MDU operations
        run_mdu("mult", OP_MULT, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1);
        model(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, m_hi, m_lo);
        run_mdu("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, m_hi, m_lo, 1'b0);
        model(OP_MULT, 32'h12345678, 32'hFFFFFFFB, m_hi, m_lo);
        run_mdu("mult_neg", OP_MULT, 32'h12345678, 32'hFFFFFFFB, m_hi, m_lo, 1'b0);
        run_mdu("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        model(OP_DIVU, 32'd100, 32'd7, m_hi, m_lo);
        run_mdu("divu", OP_DIVU, 32'd100, 32'd7, m_hi, m_lo, 1'b0);
        run_mdu("divu0", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b0);
        run_mdu("div0neg", OP_DIV, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'd1, 1'b0);
        run_mdu("divovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);

        // flush coincident with a DIV start
        clr_in();
        mdu_op = OP_DIV; in_reg1 = 32'd50; in_reg2 = 32'd5; flush = 1'b1; halt_flag_e = 1'b1;
        memory_bus = 9'h1FF; writeBack_bus = 2'b11; in_pc = 32'd8; in_sign_extend = 32'd4;
        tick();
        chk("flush_busy", {63'd0, mdu_busy}, 64'd0);
        chk("flush_alu", {32'd0, out_alu}, 64'd0);
        chk("flush_mem", {55'd0, memory_bus_out}, 64'd0);
        chk("flush_pc", {32'd0, out_pc_branch}, 64'd0);
        chk("flush_halt", {63'd0, out_halt_flag_e}, 64'd1);
        clr_in();
        tick();
        chk("halt_clr", {63'd0, out_halt_flag_e}, 64'd0);

        // reset while BUSY
        clr_in();
        mdu_op = OP_MULTU; in_reg1 = 32'd3; in_reg2 = 32'd5;
        tick();
        clr_in();
        halt_flag_e = 1'b1; in_reg1 = 32'd9;
        tick();
        tick();
        chk("pre_rst_busy", {63'd0, mdu_busy}, 64'd1);
        reset = 1'b0;
        #1;
        chk("arst_busy", {63'd0, mdu_busy}, 64'd0);
        chk("arst_alu", {32'd0, out_alu}, 64'd0);
        chk("arst_halt", {63'd0, out_halt_flag_e}, 64'd0);
        tick();
        reset = 1'b1;
        clr_in();
        mdu_op = OP_MFHI; in_reg1 = 32'd5;
        sb_push("rst_hi", 32'd0);
        tick();
        sb_check();
        mdu_op = OP_MFLO;
        sb_push("rst_lo", 32'd0);
        tick();
        sb_check();
        chk("sb_drained", exp_q.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
